rgb2gray_seq: RTL and testbench
===============================

Name: rgb2gray_seq

Overview:
Frame-level sequencer for the coprocessor's RGB444-to-gray conversion. The CPU programs source base, destination base and pixel count, then pulses start. The block streams pixels from image memory through an internal rgb2gray instance and writes the gray results back to image memory. It sustains one pixel per cycle while the memory port is granted and reports busy/done to the CPU-visible status register.

Parameters:
ADDR_W, 16, image-memory word address width
CNT_W, 16, pixel-count width; maximum job is 2^CNT_W-1 pixels

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle job start; accepted only in IDLE or DONE
abort  in  1  one-cycle cancel of the running job
src_base  in  ADDR_W  first source pixel address; sampled at start
dst_base  in  ADDR_W  first destination address; sampled at start
pix_cnt  in  CNT_W  number of pixels; sampled at start
mem_gnt  in  1  memory port granted this cycle (shared with CPU)
rd_en  out  1  read request to image memory
rd_addr  out  ADDR_W  read address
rd_data  in  12  {R[3:0],G[3:0],B[3:0]}, valid the cycle after rd_en (sync RAM)
wr_en  out  1  write strobe
wr_addr  out  ADDR_W  write address
wr_data  out  12  gray pixel word
busy  out  1  job in progress
done  out  1  sticky job-complete flag

Behaviour:
- Reset (async, any state): state IDLE; rd_en, wr_en, busy and done are 0; all address and data registers are 0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE + start: latch src_base, dst_base, pix_cnt; clear done. If pix_cnt≠0, go to RUN. If pix_cnt=0, go to DONE the next cycle with done=1 and no memory accesses.
- start in RUN or DRAIN is ignored. New parameter values presented while busy are not sampled.
- RUN, read side:
  - rd_en = mem_gnt && rd_left≠0. This is combinational from registered state; rd_addr comes from the register rd_ptr.
  - On each issued read: rd_ptr+1 and rd_left−1.
  - Cycle after an issued read: rd_data passes through rgb2gray. Gray nibble = (5R+9G+2B)>>4, range 0..15.
  - The result is registered, so wr_en is asserted 2 cycles after the corresponding rd_en. wr_addr = wr_ptr, and wr_ptr increments after each write.
  - When mem_gnt=0, no read is issued. A read or write already in the pipeline still completes; writes do not depend on mem_gnt.
- RUN → DRAIN when the last read issues. DRAIN → DONE after the last wr_en cycle. done=1 from the cycle after the final wr_en.
- busy=1 from the cycle after an accepted start through the final wr_en cycle.
- done stays high until the next accepted start or reset.
- Pointers are ADDR_W-bit and wrap modulo 2^ADDR_W. There is no error flag.
- Exactly pix_cnt reads and pix_cnt writes occur per job. Source and destination may be equal (in-place conversion is legal because each write trails its read).
- abort in RUN/DRAIN:
  - Go to IDLE next cycle with busy=0 and done=0.
  - In-flight reads are discarded and produce no write. wr_en is 0 from the cycle after abort.
  - abort in IDLE/DONE is ignored.
- start and abort in the same cycle: abort wins when busy. When not busy, start is processed.
- wr_data default format: {8'h00, gray[3:0]}.

Optional Feature:
GRAY_REPLICATE_EN
- Defined: wr_data = {gray, gray, gray}, so the result is displayable directly as RGB444.
- Undefined: wr_data = {8'h00, gray}.
- No timing or control difference between the two builds.

Test Plan:
- pix_cnt=1, src=0x0010, dst=0x0100, rd_data=0xFFF, mem_gnt=1 → rd_en at 0x0010 in the cycle after start; wr_en 2 cycles later at 0x0100 with wr_data 0x00F (0xFFF with macro); done the next cycle.
- pix_cnt=3, rd_data 0x000, 0x842, 0xF00 → wr_data 0x000, 0x005, 0x004 at dst, dst+1, dst+2. Writes occur on 3 consecutive cycles; busy stays high for those cycles.
- pix_cnt=4, mem_gnt pattern 1,0,0,1,1,0,1 → exactly 4 reads and 4 writes, addresses contiguous; each write falls exactly 2 cycles after its read.
- pix_cnt=8, abort after 3 reads issued → at most 1 further wr_en occurs, in the abort cycle itself; none afterwards. State returns to IDLE with busy=0 and done=0. A subsequent start runs a clean job.
- pix_cnt=0 start → no rd_en/wr_en; done=1 on the next cycle. A start pulse while busy changes nothing.
- src=0xFFFE, pix_cnt=3 → rd_addr sequence 0xFFFE, 0xFFFF, 0x0000. rst asserted mid-job → all outputs 0 immediately.

Source files
------------

// File: rtl/rgb2gray_seq_if.sv
// Bundles the CPU job controls, memory read/write port and status lines of rgb2gray_seq.
// The slave modport is the sequencer's view; master is the CPU/memory side.
interface rgb2gray_seq_if #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
);
    logic              i_start;
    logic              i_abort;
    logic [ADDR_W-1:0] i_src_base;
    logic [ADDR_W-1:0] i_dst_base;
    logic [CNT_W-1:0]  i_pix_cnt;
    logic              i_mem_gnt;
    logic [11:0]       i_rd_data;
    logic              o_rd_en;
    logic [ADDR_W-1:0] o_rd_addr;
    logic              o_wr_en;
    logic [ADDR_W-1:0] o_wr_addr;
    logic [11:0]       o_wr_data;
    logic              o_busy;
    logic              o_done;

    modport slave (
        input  i_start, i_abort, i_src_base, i_dst_base, i_pix_cnt, i_mem_gnt, i_rd_data,
        output o_rd_en, o_rd_addr, o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done
    );

    modport master (
        output i_start, i_abort, i_src_base, i_dst_base, i_pix_cnt, i_mem_gnt, i_rd_data,
        input  o_rd_en, o_rd_addr, o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done
    );
endinterface

// File: rtl/rgb2gray_seq.sv
// Frame sequencer streaming RGB444 pixels through rgb2gray and writing gray results back.
// Optional GRAY_REPLICATE_EN: write {gray,gray,gray} instead of {8'h00,gray}.

module rgb2gray (
    input  logic [11:0] i_rgb,
    output logic [3:0]  o_gray
);
    logic [7:0] w_sum;

    assign w_sum  = (8'd5 * {4'd0, i_rgb[11:8]}) + (8'd9 * {4'd0, i_rgb[7:4]})
                  + (8'd2 * {4'd0, i_rgb[3:0]});
    assign o_gray = 4'(w_sum >> 4);
endmodule

// state | meaning
// IDLE  | no job since reset or abort
// RUN   | reads still to issue
// DRAIN | all reads issued, waiting for trailing writes
// DONE  | job finished, done held high
module rgb2gray_seq #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic          clk,
    input  logic          rst,
    rgb2gray_seq_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0]  r_rd_left;
    logic [CNT_W-1:0]  r_wr_left;
    logic              r_rd_vld;
    logic              r_wr_en;
    logic [11:0]       r_wr_data;
    logic              r_busy;
    logic              r_done;

    logic              w_rd_en;
    logic [3:0]        w_gray;
    logic [11:0]       w_wr_word;

    assign w_rd_en = (r_state == S_RUN) && bus.i_mem_gnt && (r_rd_left != '0);

    rgb2gray u_rgb2gray (
        .i_rgb  (bus.i_rd_data),
        .o_gray (w_gray)
    );

`ifdef GRAY_REPLICATE_EN
    assign w_wr_word = {w_gray, w_gray, w_gray};
`else
    assign w_wr_word = {8'h00, w_gray};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_rd_left <= '0;
            r_wr_left <= '0;
            r_rd_vld  <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_data <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            // Pipeline stages drop out unless a running job keeps them alive.
            r_rd_vld <= 1'b0;
            r_wr_en  <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.i_start) begin
                        r_rd_ptr  <= bus.i_src_base;
                        r_wr_ptr  <= bus.i_dst_base;
                        r_rd_left <= bus.i_pix_cnt;
                        r_wr_left <= bus.i_pix_cnt;
                        if (bus.i_pix_cnt == '0) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                        end
                    end
                end
                S_RUN, S_DRAIN: begin
                    if (bus.i_abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end else begin
                        r_rd_vld <= w_rd_en;
                        r_wr_en  <= r_rd_vld;
                        if (r_rd_vld) begin
                            r_wr_data <= w_wr_word;
                        end
                        if (w_rd_en) begin
                            r_rd_ptr  <= r_rd_ptr + 1'b1;
                            r_rd_left <= r_rd_left - 1'b1;
                            if (r_rd_left == CNT_ONE) begin
                                r_state <= S_DRAIN;
                            end
                        end
                        if (r_wr_en) begin
                            r_wr_ptr  <= r_wr_ptr + 1'b1;
                            r_wr_left <= r_wr_left - 1'b1;
                            if (r_wr_left == CNT_ONE) begin
                                r_state <= S_DONE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_rd_en   = w_rd_en;
    assign bus.o_rd_addr = r_rd_ptr;
    assign bus.o_wr_en   = r_wr_en;
    assign bus.o_wr_addr = r_wr_ptr;
    assign bus.o_wr_data = r_wr_data;
    assign bus.o_busy    = r_busy;
    assign bus.o_done    = r_done;
endmodule

// File: tb/tb_rgb2gray_seq.sv
// Directed bench for rgb2gray_seq: a job-level model with expected-write queue checks every cycle,
// plus literal expectations for the documented scenarios. Honors GRAY_REPLICATE_EN.
module tb_rgb2gray_seq;
    localparam int ADDR_W = 16;
    localparam int CNT_W  = 16;

`ifdef GRAY_REPLICATE_EN
    localparam logic [11:0] EXP_FFF = 12'hFFF;
    localparam logic [11:0] EXP_842 = 12'h555;
    localparam logic [11:0] EXP_F00 = 12'h444;
`else
    localparam logic [11:0] EXP_FFF = 12'h00F;
    localparam logic [11:0] EXP_842 = 12'h005;
    localparam logic [11:0] EXP_F00 = 12'h004;
`endif

    typedef struct {
        int          cyc;
        logic [15:0] addr;
        logic [11:0] data;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rgb2gray_seq_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();
    rgb2gray_seq #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [11:0] mem [0:65535];
    always @(posedge clk) begin
        if (bus.o_rd_en) bus.i_rd_data <= mem[bus.o_rd_addr];
    end

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] gray_word(input logic [11:0] p);
        int s;
        logic [3:0] g;
        s = 5 * int'(p[11:8]) + 9 * int'(p[7:4]) + 2 * int'(p[3:0]);
        g = 4'(s / 16);
`ifdef GRAY_REPLICATE_EN
        return {g, g, g};
`else
        return {8'h00, g};
`endif
    endfunction

    // Job-level model: what reads must happen and which writes they owe, two cycles later.
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [15:0] m_src, m_dst;
    int          m_cnt, m_rd_n, m_wr_n;
    ev_t         exp_q[$];
    ev_t         rd_log[$];
    ev_t         wr_log[$];

    always @(negedge clk) begin
        logic e_rd, e_wr;
        logic [15:0] a;
        cyc++;
        if (rst) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            exp_q.delete();
        end else begin
            e_rd = m_busy && (m_rd_n < m_cnt) && bus.i_mem_gnt;
            e_wr = (exp_q.size() > 0) && (exp_q[0].cyc <= cyc);
            check("rd_en", bus.o_rd_en, e_rd);
            if (e_rd) check("rd_addr", bus.o_rd_addr, 16'(m_src + m_rd_n));
            check("wr_en", bus.o_wr_en, e_wr);
            if (e_wr) begin
                check("wr_addr", bus.o_wr_addr, exp_q[0].addr);
                check("wr_data", bus.o_wr_data, exp_q[0].data);
            end
            check("busy", bus.o_busy, m_busy);
            check("done", bus.o_done, m_done);
            if (bus.o_rd_en) rd_log.push_back('{cyc, bus.o_rd_addr, 12'h000});
            if (bus.o_wr_en) wr_log.push_back('{cyc, bus.o_wr_addr, bus.o_wr_data});

            if (m_busy && bus.i_abort) begin
                m_busy = 1'b0;
                m_done = 1'b0;
                exp_q.delete();
            end else if (!m_busy && bus.i_start) begin
                m_src  = bus.i_src_base;
                m_dst  = bus.i_dst_base;
                m_cnt  = int'(bus.i_pix_cnt);
                m_rd_n = 0;
                m_wr_n = 0;
                exp_q.delete();
                m_busy = (m_cnt != 0);
                m_done = (m_cnt == 0);
            end else if (m_busy) begin
                if (e_rd) begin
                    a = 16'(m_src + m_rd_n);
                    exp_q.push_back('{cyc + 2, 16'(m_dst + m_rd_n), gray_word(mem[a])});
                    m_rd_n++;
                end
                if (e_wr) begin
                    void'(exp_q.pop_front());
                    m_wr_n++;
                    if (m_wr_n == m_cnt) begin
                        m_busy = 1'b0;
                        m_done = 1'b1;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n);
        rd_log.delete();
        wr_log.delete();
        bus.i_src_base = s;
        bus.i_dst_base = d;
        bus.i_pix_cnt  = n;
        bus.i_start    = 1'b1;
        tick();
        bus.i_start    = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (!(bus.o_done && !bus.o_busy) && k < budget) begin
            tick();
            k++;
        end
        if (k >= budget) check("done_timeout", 32'd0, 32'd1);
        tick();
        tick();
    endtask

    initial begin
        int s_cyc, a_cyc, late, at_abort;
        logic [15:0] exp_a;
        logic [3:0] gpat [0:6];
        bus.i_start = 1'b0; bus.i_abort = 1'b0; bus.i_mem_gnt = 1'b0;
        bus.i_src_base = '0; bus.i_dst_base = '0; bus.i_pix_cnt = '0;
        for (int i = 0; i < 65536; i++) mem[i] = 12'h000;

        repeat (3) @(posedge clk);
        #1;
        check("rst_rd_en", bus.o_rd_en, 1'b0);
        check("rst_wr_en", bus.o_wr_en, 1'b0);
        check("rst_busy", bus.o_busy, 1'b0);
        check("rst_done", bus.o_done, 1'b0);
        check("rst_rd_addr", bus.o_rd_addr, 16'h0000);
        check("rst_wr_addr", bus.o_wr_addr, 16'h0000);
        check("rst_wr_data", bus.o_wr_data, 12'h000);
        rst = 1'b0;
        tick();

        // single pixel
        mem[16'h0010] = 12'hFFF;
        bus.i_mem_gnt = 1'b1;
        s_cyc = cyc + 1;
        pulse_start(16'h0010, 16'h0100, 16'd1);
        wait_done(20);
        check("t1_nrd", rd_log.size(), 1);
        check("t1_nwr", wr_log.size(), 1);
        if (rd_log.size() == 1 && wr_log.size() == 1) begin
            check("t1_rd_addr", rd_log[0].addr, 16'h0010);
            check("t1_rd_cyc", rd_log[0].cyc - s_cyc, 1);
            check("t1_wr_addr", wr_log[0].addr, 16'h0100);
            check("t1_wr_data", wr_log[0].data, EXP_FFF);
            check("t1_lat", wr_log[0].cyc - rd_log[0].cyc, 2);
        end
        check("t1_done", bus.o_done, 1'b1);

        // three pixels, start while busy ignored
        mem[16'h0200] = 12'h000; mem[16'h0201] = 12'h842; mem[16'h0202] = 12'hF00;
        pulse_start(16'h0200, 16'h0300, 16'd3);
        bus.i_src_base = 16'h0400; bus.i_dst_base = 16'h0500; bus.i_pix_cnt = 16'd5;
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        wait_done(20);
        check("t2_nrd", rd_log.size(), 3);
        check("t2_nwr", wr_log.size(), 3);
        if (wr_log.size() == 3) begin
            check("t2_d0", wr_log[0].data, 12'h000);
            check("t2_d1", wr_log[1].data, EXP_842);
            check("t2_d2", wr_log[2].data, EXP_F00);
            check("t2_a2", wr_log[2].addr, 16'h0302);
            check("t2_consec", wr_log[2].cyc - wr_log[0].cyc, 2);
        end

        // stalled grant
        gpat = '{4'd1, 4'd0, 4'd0, 4'd1, 4'd1, 4'd0, 4'd1};
        for (int i = 0; i < 4; i++) mem[16'h0A00 + 16'(i)] = 12'h3C7 + 12'(i * 291);
        bus.i_mem_gnt = 1'b0;
        pulse_start(16'h0A00, 16'h0B00, 16'd4);
        for (int i = 0; i < 7; i++) begin
            bus.i_mem_gnt = gpat[i][0];
            tick();
        end
        bus.i_mem_gnt = 1'b1;
        wait_done(30);
        check("t3_nrd", rd_log.size(), 4);
        check("t3_nwr", wr_log.size(), 4);
        if (rd_log.size() == 4 && wr_log.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                exp_a = 16'h0B00 + 16'(i);
                check("t3_wr_addr", wr_log[i].addr, exp_a);
                check("t3_lat", wr_log[i].cyc - rd_log[i].cyc, 2);
            end
        end

        // abort after three reads, then start+abort together while idle
        for (int i = 0; i < 8; i++) mem[16'h0500 + 16'(i)] = 12'h111 * 12'(i);
        pulse_start(16'h0500, 16'h0600, 16'd8);
        tick(); tick(); tick();
        bus.i_mem_gnt = 1'b0;
        bus.i_abort = 1'b1;
        a_cyc = cyc + 1;
        tick();
        bus.i_abort = 1'b0;
        bus.i_mem_gnt = 1'b1;
        repeat (6) tick();
        late = 0;
        at_abort = 0;
        foreach (wr_log[i]) begin
            if (wr_log[i].cyc > a_cyc) late++;
            if (wr_log[i].cyc == a_cyc) at_abort++;
        end
        check("t4_nrd", rd_log.size(), 3);
        check("t4_late_wr", late, 0);
        check("t4_abort_wr", at_abort, 1);
        check("t4_busy", bus.o_busy, 1'b0);
        check("t4_done", bus.o_done, 1'b0);
        bus.i_abort = 1'b1;
        pulse_start(16'h0500, 16'h0700, 16'd2);
        bus.i_abort = 1'b0;
        wait_done(20);
        check("t4_clean_nwr", wr_log.size(), 2);
        bus.i_abort = 1'b1;
        tick();
        bus.i_abort = 1'b0;
        check("t4_abort_in_done", bus.o_done, 1'b1);

        // zero-length job
        pulse_start(16'h0C00, 16'h0D00, 16'd0);
        check("t5_done_next", bus.o_done, 1'b1);
        wait_done(5);
        check("t5_nrd", rd_log.size(), 0);
        check("t5_nwr", wr_log.size(), 0);

        // address wrap
        mem[16'hFFFE] = 12'hABC; mem[16'hFFFF] = 12'h0F0; mem[16'h0000] = 12'h00F;
        pulse_start(16'hFFFE, 16'h0020, 16'd3);
        wait_done(20);
        check("t6_nrd", rd_log.size(), 3);
        if (rd_log.size() == 3) begin
            check("t6_a0", rd_log[0].addr, 16'hFFFE);
            check("t6_a1", rd_log[1].addr, 16'hFFFF);
            check("t6_a2", rd_log[2].addr, 16'h0000);
        end

        // reset mid-job
        pulse_start(16'h0500, 16'h0900, 16'd8);
        tick(); tick();
        #2;
        rst = 1'b1;
        #1;
        check("t7_rd_en", bus.o_rd_en, 1'b0);
        check("t7_wr_en", bus.o_wr_en, 1'b0);
        check("t7_busy", bus.o_busy, 1'b0);
        check("t7_done", bus.o_done, 1'b0);
        check("t7_rd_addr", bus.o_rd_addr, 16'h0000);
        check("t7_wr_addr", bus.o_wr_addr, 16'h0000);
        check("t7_wr_data", bus.o_wr_data, 12'h000);
        tick(); tick();
        rst = 1'b0;
        tick();
        pulse_start(16'h0200, 16'h0310, 16'd3);
        wait_done(20);
        check("t7_after_nwr", wr_log.size(), 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
